// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: Memory-stage inputs and registered write-back
// outputs of the MEM/WB pipeline register.
interface mem_wb_stage_if #(
    parameter int XLEN = 64
);
    logic            mem_valid;
    logic            Mem_to_Reg_recieve;
    logic            Reg_Write_recieve;
    logic [4:0]      rd_recieve;
    logic [2:0]      funct3_recieve;
    logic [XLEN-1:0] result_recieve;
    logic [XLEN-1:0] ReadData_recieve;

    logic            wb_valid;
    logic            wb_RegWrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_load_fault;

    modport master (
        output mem_valid,
        output Mem_to_Reg_recieve,
        output Reg_Write_recieve,
        output rd_recieve,
        output funct3_recieve,
        output result_recieve,
        output ReadData_recieve,
        input  wb_valid,
        input  wb_RegWrite,
        input  wb_rd,
        input  wb_data,
        input  wb_load_fault
    );

    modport slave (
        input  mem_valid,
        input  Mem_to_Reg_recieve,
        input  Reg_Write_recieve,
        input  rd_recieve,
        input  funct3_recieve,
        input  result_recieve,
        input  ReadData_recieve,
        output wb_valid,
        output wb_RegWrite,
        output wb_rd,
        output wb_data,
        output wb_load_fault
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register with load formatting,
// misalignment detection and a retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    mem_wb_stage_if.slave    bus,
    output logic [CNT_W-1:0] retired
);
    logic [2:0]      off;
    logic [2:0]      f3;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ld_data;
    logic            fault;
    logic            wr_en;
    logic [XLEN-1:0] wr_data;

    assign off = bus.result_recieve[2:0];
    assign f3  = bus.funct3_recieve;
    // Addressed lane moved down to bit 0.
    assign sh  = bus.ReadData_recieve >> {off, 3'b000};

    always_comb begin
        ld_data = sh;
        fault   = 1'b0;
        unique case (1'b1)
            f3 == 3'b111: begin
                fault = 1'b1;
            end
            f3[1:0] == 2'b00: begin
                ld_data = {{(XLEN-8){~f3[2] & sh[7]}},
                           sh[7:0]};
            end
            f3[1:0] == 2'b01: begin
                fault   = off[0];
                ld_data = {{(XLEN-16){~f3[2] & sh[15]}},
                           sh[15:0]};
            end
            f3[1:0] == 2'b10: begin
                fault   = |off[1:0];
                ld_data = {{(XLEN-32){~f3[2] & sh[31]}},
                           sh[31:0]};
            end
            default: begin
                fault = |off;
            end
        endcase
        if (!bus.Mem_to_Reg_recieve)
            fault = 1'b0;
    end

    assign wr_en = bus.mem_valid
                 & bus.Reg_Write_recieve
                 & (|bus.rd_recieve)
                 & ~fault;

    assign wr_data = (bus.Mem_to_Reg_recieve & ~fault)
                   ? ld_data : bus.result_recieve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_RegWrite   <= 1'b0;
            bus.wb_load_fault <= 1'b0;
            bus.wb_rd         <= '0;
            bus.wb_data       <= '0;
            retired           <= '0;
        end else if (flush) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_RegWrite   <= 1'b0;
            bus.wb_load_fault <= 1'b0;
            if (bus.wb_valid)
                retired <= retired + CNT_W'(1);
        end else if (!stall) begin
            if (bus.wb_valid)
                retired <= retired + CNT_W'(1);
            bus.wb_valid      <= bus.mem_valid;
            bus.wb_RegWrite   <= wr_en;
            bus.wb_load_fault <= bus.mem_valid & fault;
            bus.wb_rd         <= bus.rd_recieve;
            bus.wb_data       <= wr_data;
        end
    end
endmodule
